freq_meter: RTL

//   Gated frequency counter for an externally looped-back square wave, e.g. the NCO clock

---
 rtl/freq_meter_if.sv | 36 +++
 rtl/freq_meter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/freq_meter_if.sv
// Result/control bundle of the gated frequency meter.
//   enable      run enable into the meter (low = idle/abort)
//   meas_count  last completed window count
//   meas_valid  one-cycle strobe when meas_count updates
//   overflow    last window saturated
//   sig_lost    last window counted zero edges
//   locked      lock flag (0 unless lock detect is built in)
// Modports: master = the meter (drives results), slave = the consumer (drives enable).
interface freq_meter_if #(
  parameter int unsigned CNT_W = 24
);
  logic             enable;
  logic [CNT_W-1:0] meas_count;
  logic             meas_valid;
  logic             overflow;
  logic             sig_lost;
  logic             locked;

  modport master (
    input  enable,
    output meas_count,
    output meas_valid,
    output overflow,
    output sig_lost,
    output locked
  );

  modport slave (
    output enable,
    input  meas_count,
    input  meas_valid,
    input  overflow,
    input  sig_lost,
    input  locked
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter. Counts rising edges of the asynchronous sig_in over back-to-back
// windows of GATE_CYCLES clocks and publishes each window's count with a one-cycle strobe.
// Ports:
//   bank1_3v3_xtal_in  system clock (27 MHz crystal)
//   bank3_1v8_sys_rst  asynchronous active-low reset
//   sig_in             asynchronous signal under measurement
//   bus                freq_meter_if.master: enable in; meas_count, meas_valid, overflow,
//                      sig_lost, locked out
// Optional feature: define FREQ_METER_LOCK_DETECT_EN to build the lock comparator; otherwise
// locked is tied to 0.
module freq_meter #(
  parameter int unsigned GATE_CYCLES  = 27000,
  parameter int unsigned CNT_W        = 24,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned EXPECT_COUNT = 5000,
  parameter int unsigned TOLERANCE    = 2
) (
  input  logic         bank1_3v3_xtal_in,
  input  logic         bank3_1v8_sys_rst,
  input  logic         sig_in,
  freq_meter_if.master bus
);

  localparam int unsigned GateW = $clog2(GATE_CYCLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_GATE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic [GateW-1:0]       gate_q, gate_d;
  logic [CNT_W-1:0]       edge_q, edge_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       meas_count_q, meas_count_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   sig_lost_q, sig_lost_d;

  logic             edge_det;
  logic             gate_last;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  // Rising edge seen at the synchronizer output; the delay flop keeps each edge to one cycle.
  assign edge_det  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign gate_last = (gate_q == GateW'(GATE_CYCLES - 1));
  // Count including this cycle's edge, held at all-ones; an edge arriving at all-ones
  // is the overflow event.
  assign cnt_next  = (edge_det && !(&edge_q)) ? edge_q + 1'b1 : edge_q;
  assign ovf_next  = ovf_q | (edge_det & (&edge_q));

`ifdef FREQ_METER_LOCK_DETECT_EN
  localparam logic [CNT_W:0] ExpVal = (CNT_W + 1)'(EXPECT_COUNT);

  logic             locked_q, locked_d;
  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   cnt_diff;
  logic             lock_next;

  always_comb begin
    cnt_ext   = {1'b0, cnt_next};
    cnt_diff  = (cnt_ext >= ExpVal) ? (cnt_ext - ExpVal) : (ExpVal - cnt_ext);
    lock_next = (32'(cnt_diff) <= TOLERANCE) && !ovf_next;
  end
`endif

  always_comb begin
    state_d      = state_q;
    gate_d       = gate_q;
    edge_d       = edge_q;
    ovf_d        = ovf_q;
    meas_count_d = meas_count_q;
    meas_valid_d = 1'b0;
    overflow_d   = overflow_q;
    sig_lost_d   = sig_lost_q;
`ifdef FREQ_METER_LOCK_DETECT_EN
    locked_d     = locked_q;
`endif
    if (!bus.enable) begin
      // Abort: the partial window is dropped, published results hold.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM: begin
          gate_d  = '0;
          edge_d  = '0;
          ovf_d   = 1'b0;
          state_d = ST_GATE;
        end
        ST_GATE: begin
          if (gate_last) begin
            // Boundary cycle's edge belongs to the closing window; the next window
            // starts immediately with no dead cycle.
            gate_d       = '0;
            edge_d       = '0;
            ovf_d        = 1'b0;
            meas_count_d = cnt_next;
            meas_valid_d = 1'b1;
            overflow_d   = ovf_next;
            sig_lost_d   = (cnt_next == '0);
`ifdef FREQ_METER_LOCK_DETECT_EN
            locked_d     = lock_next;
`endif
          end else begin
            gate_d = gate_q + 1'b1;
            edge_d = cnt_next;
            ovf_d  = ovf_next;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge bank1_3v3_xtal_in or negedge bank3_1v8_sys_rst) begin
    if (!bank3_1v8_sys_rst) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      dly_q        <= 1'b0;
      gate_q       <= '0;
      edge_q       <= '0;
      ovf_q        <= 1'b0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      sig_lost_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], sig_in};
      dly_q        <= sync_q[SYNC_STAGES-1];
      gate_q       <= gate_d;
      edge_q       <= edge_d;
      ovf_q        <= ovf_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      overflow_q   <= overflow_d;
      sig_lost_q   <= sig_lost_d;
    end
  end

`ifdef FREQ_METER_LOCK_DETECT_EN
  always_ff @(posedge bank1_3v3_xtal_in or negedge bank3_1v8_sys_rst) begin
    if (!bank3_1v8_sys_rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end

  assign bus.locked = locked_q;
`else
  assign bus.locked = 1'b0;
`endif

  assign bus.meas_count = meas_count_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.sig_lost   = sig_lost_q;

endmodule
